finite_dev_arbiter: RTL and testbench

Round-robin arbiter that shares one instance of the Finite `dev` datapath among `N_REQ` requesters. The datapath computes `(x + 1) mod 100` on a 7-bit operand. The block accepts one operand per cycle from the granted requester and registers the result with the winner's ID. It holds the result until the downstream consumer accepts it. It sits between the stimulus-side producers and the single datapath instance in the Finite regression top.

---
 rtl/finite_dev_arbiter.sv | 135 +++++++++++++
 tb/tb_finite_dev_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/finite_dev_arbiter.sv
// Round-robin arbiter sharing one (x+1) mod 100 datapath among N_REQ requesters.
// Optional macro FINITE_ARB_RANGE_CHECK_EN: operands >= 100 load rsp_err=1, rsp_data=0.
module finite_dev_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*7-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [6:0]         rsp_data,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [ID_W-1:0] LAST = ID_W'(N_REQ - 1);

  state_t            state;
  state_t            stateNext;
  logic [ID_W-1:0]   rrPtr;
  logic [ID_W-1:0]   grantIdx;
  logic [N_REQ-1:0]  hiValid;
  logic              anyValid;
  logic              anyHi;
  logic              free;
  logic              xfer;
  logic [6:0]        grantOp;
  logic [6:0]        dataQ;
  logic [ID_W-1:0]   idQ;

  function automatic logic [6:0] dev(input logic [6:0] x);
    logic [6:0] s;
    logic [7:0] m;
    s = x + 7'd1;
    m = {1'b0, s} % 8'd100;
    return m[6:0];
  endfunction

  // Requests at or above the pointer win; otherwise wrap to the lowest.
  always_comb begin
    hiValid  = '0;
    grantIdx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      hiValid[i] = req_valid[i] && (i >= int'(rrPtr));
    end
    anyValid = |req_valid;
    anyHi    = |hiValid;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (anyHi ? hiValid[i] : req_valid[i]) begin
        grantIdx = ID_W'(i);
      end
    end
  end

  always_comb begin
    grantOp = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grantIdx == ID_W'(i)) begin
        grantOp = req_data[7*i +: 7];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    free      = 1'b0;
    xfer      = 1'b0;
    req_ready = '0;
    unique case (state)
      EMPTY: free = 1'b1;
      FULL:  free = rsp_ready;
      default: free = 1'b0;
    endcase
    xfer = free && anyValid;
    if (xfer) begin
      req_ready[grantIdx] = 1'b1;
      stateNext = FULL;
    end else if (state == FULL && rsp_ready) begin
      stateNext = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rrPtr <= '0;
      dataQ <= '0;
      idQ   <= '0;
    end else if (xfer) begin
      rrPtr <= (grantIdx == LAST) ? '0 : grantIdx + 1'b1;
      idQ   <= grantIdx;
`ifdef FINITE_ARB_RANGE_CHECK_EN
      dataQ <= (grantOp >= 7'd100) ? 7'd0 : dev(grantOp);
`else
      dataQ <= dev(grantOp);
`endif
    end
  end

`ifdef FINITE_ARB_RANGE_CHECK_EN
  logic errQ;

  always_ff @(posedge clk) begin
    if (!rst) begin
      errQ <= 1'b0;
    end else if (xfer) begin
      errQ <= (grantOp >= 7'd100);
    end
  end

  assign rsp_err = errQ;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_valid = (state == FULL);
  assign rsp_data  = dataQ;
  assign rsp_id    = idQ;

endmodule

// File: tb/tb_finite_dev_arbiter.sv
// Bench for finite_dev_arbiter: directed vector table, hand sequences,
// and randomized traffic against a queue-free behavioural model.
module tb_finite_dev_arbiter;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [27:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [6:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  finite_dev_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_id(rsp_id),
    .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rs;
    logic [3:0]  v;
    logic [27:0] d;
    logic        rr;
    logic [3:0]  eRdy;
    logic        eVal;
    logic [6:0]  eData;
    logic [1:0]  eId;
    logic        eErr;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: result slot, owner, and round-robin start point.
  bit mFull;
  int mPtr;
  int mData;
  int mId;
  bit mErr;

  function automatic int opOf(int i);
    return int'((req_data >> (7 * i)) & 28'h7f);
  endfunction

  function automatic int refDev(int x);
    return ((x + 1) % 128) % 100;
  endfunction

  function automatic int pick();
    if (mFull && !rsp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mPtr + k) % N;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    int x;
    if (!rst) begin
      mFull = 0; mPtr = 0; mData = 0; mId = 0; mErr = 0;
    end else begin
      g = pick();
      if (g >= 0) begin
        x = opOf(g);
`ifdef FINITE_ARB_RANGE_CHECK_EN
        mErr  = (x >= 100);
        mData = mErr ? 0 : refDev(x);
`else
        mErr  = 0;
        mData = refDev(x);
`endif
        mId   = g;
        mFull = 1;
        mPtr  = (g + 1) % N;
      end else if (mFull && rsp_ready) begin
        mFull = 0;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] pk(int a, int b, int c, int e);
    return {7'(e), 7'(c), 7'(b), 7'(a)};
  endfunction

  function automatic vec_t mk(
    logic rs, logic [3:0] v, logic [27:0] d, logic rr,
    logic [3:0] eRdy, logic eVal, int eData, int eId, logic eErr);
    vec_t t;
    t.rs = rs; t.v = v; t.d = d; t.rr = rr;
    t.eRdy = eRdy; t.eVal = eVal;
    t.eData = 7'(eData); t.eId = 2'(eId); t.eErr = eErr;
    return t;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic apply(input vec_t t, input string nm);
    rst = t.rs; req_valid = t.v; req_data = t.d; rsp_ready = t.rr;
    #1;
    if (t.rs) chk({nm, " req_ready"}, int'(req_ready), int'(t.eRdy));
    @(posedge clk);
    @(negedge clk);
    chk({nm, " rsp_valid"}, int'(rsp_valid), int'(t.eVal));
    chk({nm, " rsp_data"}, int'(rsp_data), int'(t.eData));
    chk({nm, " rsp_id"}, int'(rsp_id), int'(t.eId));
    chk({nm, " rsp_err"}, int'(rsp_err), int'(t.eErr));
  endtask

  logic [27:0] all4;
  int d126;
  int d127;
  logic e126;

  initial begin
    all4 = pk(10, 20, 30, 40);
`ifdef FINITE_ARB_RANGE_CHECK_EN
    d126 = 0; d127 = 0; e126 = 1'b1;
`else
    d126 = 27; d127 = 0; e126 = 1'b0;
`endif
    tbl.push_back(mk(1, 4'b0100, pk(0, 0, 50, 0), 1, 4'b0100, 1, 51, 2, 0));
    tbl.push_back(mk(1, 4'b1111, all4, 1, 4'b1000, 1, 41, 3, 0));
    tbl.push_back(mk(1, 4'b1111, all4, 1, 4'b0001, 1, 11, 0, 0));
    tbl.push_back(mk(1, 4'b1111, all4, 1, 4'b0010, 1, 21, 1, 0));
    tbl.push_back(mk(1, 4'b1111, all4, 1, 4'b0100, 1, 31, 2, 0));
    tbl.push_back(mk(1, 4'b1111, all4, 1, 4'b1000, 1, 41, 3, 0));
    tbl.push_back(mk(1, 4'b1111, all4, 1, 4'b0001, 1, 11, 0, 0));
    tbl.push_back(mk(1, 4'b1111, all4, 1, 4'b0010, 1, 21, 1, 0));
    tbl.push_back(mk(1, 4'b1111, all4, 1, 4'b0100, 1, 31, 2, 0));
    tbl.push_back(mk(1, 4'b1111, all4, 1, 4'b1000, 1, 41, 3, 0));
    tbl.push_back(mk(1, 4'b0000, all4, 1, 4'b0000, 0, 41, 3, 0));
    tbl.push_back(mk(1, 4'b0001, pk(98, 0, 0, 0), 0, 4'b0001, 1, 99, 0, 0));
    tbl.push_back(mk(1, 4'b0010, pk(0, 5, 0, 0), 0, 4'b0000, 1, 99, 0, 0));
    tbl.push_back(mk(1, 4'b0010, pk(0, 5, 0, 0), 0, 4'b0000, 1, 99, 0, 0));
    tbl.push_back(mk(1, 4'b0000, pk(0, 5, 0, 0), 0, 4'b0000, 1, 99, 0, 0));
    tbl.push_back(mk(1, 4'b0010, pk(0, 5, 0, 0), 0, 4'b0000, 1, 99, 0, 0));
    tbl.push_back(mk(1, 4'b0010, pk(0, 5, 0, 0), 1, 4'b0010, 1, 6, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 28'd0, 1, 4'b0000, 0, 6, 1, 0));
    tbl.push_back(mk(1, 4'b0001, pk(99, 0, 0, 0), 1, 4'b0001, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0010, pk(0, 126, 0, 0), 1, 4'b0010, 1, d126, 1, e126));
    tbl.push_back(mk(1, 4'b0100, pk(0, 0, 127, 0), 1, 4'b0100, 1, d127, 2, e126));
    tbl.push_back(mk(1, 4'b0000, 28'd0, 1, 4'b0000, 0, d127, 2, e126));

    rst = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset rsp_valid", int'(rsp_valid), 0);
    chk("reset rsp_data", int'(rsp_data), 0);
    chk("reset rsp_id", int'(rsp_id), 0);
    chk("reset rsp_err", int'(rsp_err), 0);
    rst = 1'b1;
    #1;
    chk("reset req_ready", int'(req_ready), 0);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset while holding a result from requester 1 (pointer at 2).
    apply(mk(1, 4'b0010, pk(0, 60, 0, 0), 0, 4'b0010, 1, 61, 1, 0), "mrst load");
    apply(mk(0, 4'b0000, 28'd0, 0, 4'b0000, 0, 0, 0, 0), "mrst clear");
    apply(mk(1, 4'b1111, all4, 1, 4'b0001, 1, 11, 0, 0), "mrst regrant");

    // Requester 1 flickers while the slot is held.
    apply(mk(1, 4'b0010, all4, 0, 4'b0000, 1, 11, 0, 0), "drop req");
    apply(mk(1, 4'b0000, all4, 0, 4'b0000, 1, 11, 0, 0), "drop hold");
    apply(mk(1, 4'b0000, all4, 1, 4'b0000, 0, 11, 0, 0), "drop accept");
    apply(mk(1, 4'b0000, all4, 1, 4'b0000, 0, 11, 0, 0), "drop idle");

    for (int c = 0; c < 400; c++) begin
      int g;
      rst       = ($urandom % 50) != 0;
      req_valid = 4'($urandom);
      req_data  = 28'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      #1;
      if (rst) begin
        g = pick();
        chk("rnd req_ready", int'(req_ready),
            (g >= 0) ? (1 << g) : 0);
      end
      @(posedge clk);
      @(negedge clk);
      chk("rnd rsp_valid", int'(rsp_valid), int'(mFull));
      chk("rnd rsp_data", int'(rsp_data), mData);
      chk("rnd rsp_id", int'(rsp_id), mId);
      chk("rnd rsp_err", int'(rsp_err), int'(mErr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
